// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
// Optional ovf output is enabled by defining SERIAL_ADD_OVF_EN.
package serial_adder_ctrl_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/add_bit_slice.sv
// One-bit full adder built from two half adders; the only arithmetic in the datapath.
module add_bit_slice (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a (x),
        .b (y),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder; building block of the serial adder slice.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first, one bit per clock.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_sr_q, a_sr_d;
    logic [WIDTH-1:0]  b_sr_q, b_sr_d;
    logic [WIDTH-2:0]  res_sr_q, res_sr_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic              slice_s;
    logic              slice_co;
    // Partial result with the current bit prepended; complete on the last RUN cycle.
    logic [WIDTH-1:0]  res_ext;

    add_bit_slice u_slice (
        .x   (a_sr_q[0]),
        .y   (b_sr_q[0]),
        .cin (carry_q),
        .s   (slice_s),
        .co  (slice_co)
    );

    assign res_ext = {slice_s, res_sr_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    res_sr_d = '0;
                    carry_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_ext[WIDTH-1:1];
                carry_d  = slice_co;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                    sum_d   = res_ext;
                    cout_d  = slice_co;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB during the final bit.
                    ovf_d   = carry_q ^ slice_co;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8); checks ovf when SERIAL_ADD_OVF_EN is set.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf_obs;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
    assign ovf_obs = ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer addition of the unsigned operands.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned t;
        t = int'(x) + int'(y);
        return t[W:0];
    endfunction

    // Reference: signed overflow when same-sign operands give an opposite-sign result.
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_ADD_OVF_EN
        int sx, sy, st;
        sx = (x >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
        sy = (y >= (1 << (W - 1))) ? int'(y) - (1 << W) : int'(y);
        st = sx + sy;
        return (st > (1 << (W - 1)) - 1) || (st < -(1 << (W - 1)));
`else
        return 1'b0;
`endif
    endfunction

    // Runs one operation and reports what was observed; comparisons live in the callers.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         output logic busy_after, output int cycles,
                         output logic [W-1:0] got_sum, output logic got_cout,
                         output logic got_ovf, output logic moved, output logic lingered);
        logic [W-1:0] prev_sum;
        logic         prev_cout;
        start = 1'b1;
        a     = xa;
        b     = xb;
        tick();
        start      = 1'b0;
        a          = W'($urandom);
        b          = W'($urandom);
        busy_after = busy;
        prev_sum   = sum;
        prev_cout  = cout;
        moved      = 1'b0;
        cycles     = 0;
        while (done !== 1'b1 && cycles < 40) begin
            if (sum !== prev_sum || cout !== prev_cout) moved = 1'b1;
            tick();
            cycles++;
        end
        got_sum  = sum;
        got_cout = cout;
        got_ovf  = ovf_obs;
        tick();
        lingered = done | busy;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb);
        logic         busy_after, got_cout, got_ovf, moved, lingered;
        logic [W-1:0] got_sum;
        logic [W:0]   exp;
        int           cycles;
        exp = ref_add(xa, xb);
        do_op(xa, xb, busy_after, cycles, got_sum, got_cout, got_ovf, moved, lingered);
        n_checks++;
        if (busy_after !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy: got %b want 1", name, busy_after);
        end
        n_checks++;
        if (cycles != W) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, cycles, W);
        end
        n_checks++;
        if ({got_cout, got_sum} !== exp) begin
            n_fail++;
            $display("FAIL %s a=%h b=%h result: got cout=%b sum=%h want cout=%b sum=%h",
                     name, xa, xb, got_cout, got_sum, exp[W], exp[W-1:0]);
        end
`ifdef SERIAL_ADD_OVF_EN
        n_checks++;
        if (got_ovf !== ref_ovf(xa, xb)) begin
            n_fail++;
            $display("FAIL %s a=%h b=%h ovf: got %b want %b", name, xa, xb, got_ovf,
                     ref_ovf(xa, xb));
        end
`endif
        n_checks++;
        if (moved !== 1'b0) begin
            n_fail++;
            $display("FAIL %s outputs changed before done: got 1 want 0", name);
        end
        n_checks++;
        if (lingered !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done/busy after done cycle: got %b want 0", name, lingered);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        n_checks++;
        if ({busy, done, sum, cout, ovf_obs} !== '0) begin
            n_fail++;
            $display("FAIL reset: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, ovf_obs);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        check_op("zero", 8'h00, 8'h00);
        check_op("ripple", 8'hFF, 8'h01);
        check_op("5a3c", 8'h5A, 8'h3C);
        check_op("f020", 8'hF0, 8'h20);
        check_op("max", 8'hFF, 8'hFF);
        check_op("negovf", 8'h80, 8'h80);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            check_op("random", W'($urandom), W'($urandom));
        end
    endtask

    task automatic test_ignore_start();
        int n_done;
        int cyc;
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        tick();
        start = 1'b0;
        cyc   = 3;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc != W) begin
            n_fail++;
            $display("FAIL ignore latency: got %0d want %0d", cyc, W);
        end
        n_checks++;
        if (sum !== 8'h33 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore result: got sum=%h cout=%b want sum=33 cout=0", sum, cout);
        end
        n_done = 0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL ignore extra done: got %0d pulses want 0", n_done);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_done;
        start = 1'b1;
        a     = 8'hC3;
        b     = 8'h7E;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, sum, cout, ovf_obs} !== '0) begin
            n_fail++;
            $display("FAIL midreset: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, ovf_obs);
        end
        n_done = 0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL midreset done pulse: got %0d want 0", n_done);
        end
        check_op("after_reset", 8'h01, 8'h01);
    endtask

    task automatic test_back_to_back();
        int           pulses[$];
        logic [W-1:0] xa, xb;
        logic [W:0]   exp;
        logic         bad_val;
        xa      = 8'h9C;
        xb      = 8'hA7;
        exp     = ref_add(xa, xb);
        bad_val = 1'b0;
        start   = 1'b1;
        a       = xa;
        b       = xb;
        for (int c = 1; c <= 35; c++) begin
            tick();
            if (done === 1'b1) pulses.push_back(c);
            if (pulses.size() > 0 && {cout, sum} !== exp) bad_val = 1'b1;
        end
        start = 1'b0;
        n_checks++;
        if (pulses.size() != 3) begin
            n_fail++;
            $display("FAIL b2b pulse count: got %0d want 3", pulses.size());
        end
        for (int i = 1; i < pulses.size(); i++) begin
            n_checks++;
            if (pulses[i] - pulses[i-1] != W + 2) begin
                n_fail++;
                $display("FAIL b2b spacing: got %0d want %0d", pulses[i] - pulses[i-1], W + 2);
            end
        end
        n_checks++;
        if (bad_val !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b sum stability: got unstable want stable %h", exp);
        end
        for (int i = 0; i < W + 4; i++) tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
